// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and Johnson-code helpers for the up/down modulo counter.
// Helpers take a fixed-size argument plus the live width so one function serves every WIDTH.
package updown_mod_counter_pkg;

    localparam int MODE_BIN     = 0;
    localparam int MODE_JOHNSON = 1;

    // Widest counter the Johnson helpers can describe.
    localparam int JMAX = 32;

    // A Johnson code has at most one place where neighbouring bits differ (not wrapping around).
    function automatic logic johnson_valid(input logic [JMAX-1:0] code, input int width);
        int edges;
        edges = 0;
        for (int i = 0; i < JMAX - 1; i++) begin
            if ((i < width - 1) && (code[i] != code[i+1])) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

    function automatic logic [JMAX-1:0] johnson_term_up(input int width);
        logic [JMAX-1:0] code;
        code = '0;
        if (width > 0) begin
            code[0] = 1'b1;
        end
        return code;
    endfunction

    function automatic logic [JMAX-1:0] johnson_term_dn(input int width);
        logic [JMAX-1:0] code;
        code = '0;
        for (int i = 0; i < JMAX; i++) begin
            if (i == width - 1) begin
                code[i] = 1'b1;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle between a counter and whatever sequences it.
// The master drives enable/direction/load; the slave (counter) returns the count and terminal flag.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;

    modport master (
        output en, up, load, d,
        input  q, qb, tc
    );

    modport slave (
        input  en, up, load, d,
        output q, qb, tc
    );

endinterface

// File: rtl/updown_mod_counter_cnt_next_state.sv
// Pure combinational step logic: the counted successor, the sanitised load value and the terminal match.
// Enable/load arbitration and the register itself live in the top level.
module cnt_next_state
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int MODE     = MODE_BIN,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_q,
    output logic [WIDTH-1:0] load_q,
    output logic             at_term
);

    generate
        if (MODE == MODE_JOHNSON) begin : g_johnson
            localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(johnson_term_up(WIDTH));
            localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(johnson_term_dn(WIDTH));

            logic q_valid;
            logic d_valid;
            logic [WIDTH-1:0] term;

            assign q_valid = johnson_valid(JMAX'(q), WIDTH);
            assign d_valid = johnson_valid(JMAX'(d), WIDTH);
            assign term    = up ? TERM_UP : TERM_DN;

            // An illegal pattern collapses to zero so the ring recovers in one enabled edge.
            always_comb begin
                next_q  = '0;
                load_q  = '0;
                at_term = 1'b0;
                if (d_valid) begin
                    load_q = d;
                end
                if (q_valid) begin
                    at_term = (q == term);
                    if (at_term && (SATURATE != 0)) begin
                        next_q = q;
                    end else if (up) begin
                        next_q = {~q[0], q[WIDTH-1:1]};
                    end else begin
                        next_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
                    end
                end
            end
        end else begin : g_binary
            localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
            localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

            logic q_in_range;
            logic d_in_range;
            logic [WIDTH-1:0] term;

            assign q_in_range = ({1'b0, q} < MOD_W);
            assign d_in_range = ({1'b0, d} < MOD_W);
            assign term       = up ? LAST : '0;

            // Out-of-range counts (only reachable by upset) fall back to zero.
            always_comb begin
                next_q  = '0;
                load_q  = '0;
                at_term = 1'b0;
                if (d_in_range) begin
                    load_q = d;
                end
                if (q_in_range) begin
                    at_term = (q == term);
                    if (at_term) begin
                        if (SATURATE != 0) begin
                            next_q = q;
                        end else begin
                            next_q = up ? '0 : LAST;
                        end
                    end else if (up) begin
                        next_q = q + WIDTH'(1);
                    end else begin
                        next_q = q - WIDTH'(1);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter, binary modulo-N or self-correcting Johnson ring, with load, enable and saturation.
// tc is en-qualified so stage n+1 can take stage n's tc as its enable.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int MODE     = MODE_BIN,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 clr,
    updown_mod_counter_if.slave  bus
);

    generate
        if (WIDTH < 2 || WIDTH > JMAX) begin : g_bad_width
            $error("updown_mod_counter: WIDTH must be in 2..32");
        end
        if (MODE != MODE_BIN && MODE != MODE_JOHNSON) begin : g_bad_mode
            $error("updown_mod_counter: MODE must be 0 or 1");
        end
        if (MODE == MODE_BIN &&
            (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] load_q;
    logic             term_hit;

    cnt_next_state #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .MODE     (MODE),
        .SATURATE (SATURATE)
    ) u_next (
        .q       (count_q),
        .up      (bus.up),
        .d       (bus.d),
        .next_q  (step_q),
        .load_q  (load_q),
        .at_term (term_hit)
    );

    // Load outranks enable; with neither asserted the count simply holds.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
        end else if (bus.load) begin
            count_q <= load_q;
        end else if (bus.en) begin
            count_q <= step_q;
        end
    end

    assign bus.q  = count_q;
    assign bus.qb = ~count_q;
    assign bus.tc = bus.en & term_hit;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: binary wrap, binary saturate and Johnson counters driven side by side.
// Stimulus pushes expectations from a sequence-level model; monitors pop and compare.
`timescale 1ns/100ps
module tb_updown_mod_counter;

    typedef struct {
        int         inst;
        logic [3:0] val;
    } expT;

    logic clk;
    logic clr;

    bit         drvEn[3];
    bit         drvUp[3];
    bit         drvLoad[3];
    logic [3:0] drvD[3];

    logic [3:0] qv[3];
    logic [3:0] qbv[3];
    logic       tcv[3];

    logic [3:0] mq[3];
    expT        qExp[$];
    expT        tcExp[$];

    int total;
    int bad;

    int         modOf[3]  = '{10, 10, 0};
    bit         satOf[3]  = '{1'b0, 1'b1, 1'b0};
    bit         isJ[3]    = '{1'b0, 1'b0, 1'b1};
    logic [3:0] jseq[8]   = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};

    updown_mod_counter_if #(.WIDTH(4)) ifB0 ();
    updown_mod_counter_if #(.WIDTH(4)) ifB1 ();
    updown_mod_counter_if #(.WIDTH(4)) ifJ  ();

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .MODE(0), .SATURATE(0))
        uB0 (.clk(clk), .clr(clr), .bus(ifB0));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .MODE(0), .SATURATE(1))
        uB1 (.clk(clk), .clr(clr), .bus(ifB1));
    updown_mod_counter #(.WIDTH(4), .MODULUS(16), .MODE(1), .SATURATE(0))
        uJ  (.clk(clk), .clr(clr), .bus(ifJ));

    assign ifB0.en = drvEn[0];   assign ifB0.up = drvUp[0];
    assign ifB0.load = drvLoad[0]; assign ifB0.d = drvD[0];
    assign ifB1.en = drvEn[1];   assign ifB1.up = drvUp[1];
    assign ifB1.load = drvLoad[1]; assign ifB1.d = drvD[1];
    assign ifJ.en = drvEn[2];    assign ifJ.up = drvUp[2];
    assign ifJ.load = drvLoad[2];  assign ifJ.d = drvD[2];

    assign qv[0] = ifB0.q;  assign qbv[0] = ifB0.qb;  assign tcv[0] = ifB0.tc;
    assign qv[1] = ifB1.q;  assign qbv[1] = ifB1.qb;  assign tcv[1] = ifB1.tc;
    assign qv[2] = ifJ.q;   assign qbv[2] = ifJ.qb;   assign tcv[2] = ifJ.tc;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Position of a code in the Johnson ring, -1 when the code is not on the ring.
    function automatic int jIndex(input logic [3:0] v);
        for (int k = 0; k < 8; k++) begin
            if (jseq[k] === v) return k;
        end
        return -1;
    endfunction

    function automatic bit modelTc(input int i, input logic [3:0] cur, input bit en, input bit up);
        if (!en) return 1'b0;
        if (isJ[i]) return up ? (cur === 4'b0001) : (cur === 4'b1000);
        return up ? (int'(cur) == modOf[i] - 1) : (cur === 4'd0);
    endfunction

    function automatic logic [3:0] modelNext(input int i, input logic [3:0] cur, input bit en,
                                             input bit up, input bit load, input logic [3:0] d);
        int idx;
        int v;
        if (load) begin
            if (isJ[i]) return (jIndex(d) >= 0) ? d : 4'd0;
            return (int'(d) < modOf[i]) ? d : 4'd0;
        end
        if (!en) return cur;
        if (isJ[i]) begin
            idx = jIndex(cur);
            if (idx < 0) return 4'd0;
            if (satOf[i] && modelTc(i, cur, en, up)) return cur;
            return jseq[up ? (idx + 1) % 8 : (idx + 7) % 8];
        end
        v = int'(cur);
        if (v >= modOf[i]) return 4'd0;
        if (satOf[i] && modelTc(i, cur, en, up)) return cur;
        v = up ? (v + 1) % modOf[i] : (v + modOf[i] - 1) % modOf[i];
        return 4'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one counter for the coming edge and records what it must show now and after the edge.
    task automatic applyStimulus(input int i, input bit en, input bit up, input bit load,
                                 input logic [3:0] d);
        expT e;
        drvEn[i]   = en;
        drvUp[i]   = up;
        drvLoad[i] = load;
        drvD[i]    = d;
        e.inst = i;
        e.val  = {3'b000, modelTc(i, mq[i], en, up)};
        tcExp.push_back(e);
        mq[i]  = modelNext(i, mq[i], en, up, load, d);
        e.val  = mq[i];
        qExp.push_back(e);
    endtask

    task automatic allCycle(input bit en, input bit up, input bit load, input logic [3:0] d);
        @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(i, en, up, load, d);
    endtask

    always begin : qMonitor
        expT e;
        @(posedge clk);
        #1;
        while (qExp.size() > 0) begin
            e = qExp.pop_front();
            checkOutput($sformatf("q[%0d]", e.inst), qv[e.inst], e.val);
            checkOutput($sformatf("qb[%0d]", e.inst), qbv[e.inst], ~e.val);
        end
    end

    always begin : tcMonitor
        expT e;
        @(negedge clk);
        #2;
        while (tcExp.size() > 0) begin
            e = tcExp.pop_front();
            checkOutput($sformatf("tc[%0d]", e.inst), {3'b000, tcv[e.inst]}, e.val);
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        clr   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drvEn[i] = 1'b0; drvUp[i] = 1'b0; drvLoad[i] = 1'b0; drvD[i] = 4'd0; mq[i] = 4'd0;
        end
        #5;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset q[%0d]", i), qv[i], 4'd0);
            checkOutput($sformatf("reset qb[%0d]", i), qbv[i], 4'hF);
        end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;

        for (int n = 0; n < 12; n++) allCycle(1'b1, 1'b1, 1'b0, 4'd0);
        allCycle(1'b0, 1'b1, 1'b1, 4'd0);
        for (int n = 0; n < 12; n++) allCycle(1'b1, 1'b0, 1'b0, 4'd0);
        for (int n = 0; n < 3; n++) allCycle(1'b0, 1'b1, 1'b0, 4'd0);

        allCycle(1'b1, 1'b1, 1'b1, 4'd12);
        allCycle(1'b1, 1'b1, 1'b1, 4'd5);
        allCycle(1'b1, 1'b1, 1'b1, 4'd9);
        allCycle(1'b1, 1'b0, 1'b1, 4'd8);

        for (int n = 0; n < 8; n++) allCycle(1'b1, 1'b1, 1'b0, 4'd0);
        for (int n = 0; n < 8; n++) allCycle(1'b1, 1'b0, 1'b0, 4'd0);

        // Plant an off-ring Johnson pattern directly in the register, then let one enabled edge repair it.
        @(negedge clk);
        force uJ.count_q = 4'b0101;
        mq[2] = 4'b0101;
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(2, 1'b1, 1'b1, 1'b0, 4'd0);
        #3;
        release uJ.count_q;

        for (int n = 0; n < 5; n++) allCycle(1'b1, 1'b1, 1'b0, 4'd0);
        allCycle(1'b1, 1'b1, 1'b0, 4'd0);
        #3;
        clr = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("async q[%0d]", i), qv[i], 4'd0);
            checkOutput($sformatf("async qb[%0d]", i), qbv[i], 4'hF);
        end
        qExp.delete();
        #2;
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expT e;
            mq[i] = modelNext(i, 4'd0, drvEn[i], drvUp[i], drvLoad[i], drvD[i]);
            e.inst = i;
            e.val  = mq[i];
            qExp.push_back(e);
        end
        for (int n = 0; n < 4; n++) allCycle(1'b1, 1'b1, 1'b0, 4'd0);

        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                applyStimulus(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                              ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drvEn[i] = 1'b0; drvLoad[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        if (qExp.size() != 0 || tcExp.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d/%0d pending expected 0/0", qExp.size(), tcExp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
